// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock with an on-the-fly key schedule.
// The handshake is valid/ready on both sides, and the ciphertext output is registered.
module aes_encrypt_core (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   // Forward S-box. Byte x sits at bits [2047-8x -: 8].
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] b);
      logic [127:0] r;
      r = 128'h0;
      for (int n = 0; n < 16; n++) r[127-8*n -: 8] = sbox(b[127-8*n -: 8]);
      return r;
   endfunction

   // Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] b);
      logic [127:0] r;
      r = 128'h0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = b[127-8*(4*((c+w)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] b);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = b[127-32*c -: 8];
         a1 = b[119-32*c -: 8];
         a2 = b[111-32*c -: 8];
         a3 = b[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = rk[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   fsm_e         fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] rk_q, rk_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] ciphertext_q, ciphertext_d;
   logic [127:0] next_rk_s, sr_s, mc_s;

   // Next-state and round datapath.
   always_comb begin
      fsm_d        = fsm_q;
      blk_d        = blk_q;
      rk_d         = rk_q;
      rcon_d       = rcon_q;
      rnd_d        = rnd_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      ciphertext_d = ciphertext_q;
      next_rk_s    = key_expand(rk_q, rcon_q);
      sr_s         = shift_rows(sub_bytes(blk_q));
      mc_s         = mix_columns(sr_s);
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               blk_d      = plaintext ^ key;
               rk_d       = key;
               rcon_d     = 8'h01;
               rnd_d      = 4'd1;
               in_ready_d = 1'b0;
               fsm_d      = ST_RUN;
            end else begin
               fsm_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            rk_d   = next_rk_s;
            rcon_d = xtime(rcon_q);
            rnd_d  = rnd_q + 4'd1;
            if (rnd_q == 4'd10) begin
               // Final round omits MixColumns; the result goes straight to the output register.
               blk_d        = sr_s ^ next_rk_s;
               ciphertext_d = sr_s ^ next_rk_s;
               out_valid_d  = 1'b1;
               fsm_d        = ST_DONE;
            end else begin
               blk_d = mc_s ^ next_rk_s;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               fsm_d       = ST_IDLE;
            end else begin
               fsm_d = ST_DONE;
            end
         end
         default: begin
            fsm_d       = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q        <= ST_IDLE;
         blk_q        <= 128'h0;
         rk_q         <= 128'h0;
         rcon_q       <= 8'h00;
         rnd_q        <= 4'd0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         ciphertext_q <= 128'h0;
      end else begin
         fsm_q        <= fsm_d;
         blk_q        <= blk_d;
         rk_q         <= rk_d;
         rcon_q       <= rcon_d;
         rnd_q        <= rnd_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         ciphertext_q <= ciphertext_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors plus random blocks
// checked against an array-based AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_encrypt_core;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] sbox_tab [256];

   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes_encrypt_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .plaintext (plaintext),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ciphertext(ciphertext)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b};
      return t[15-n -: 8];
   endfunction

   // S-box from the definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         end
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) s[n] = sbox_tab[s[n]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
      end
      res = 128'h0;
      for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Waits for in_ready, then presents the block for exactly one accepting edge.
   task automatic accept_block(input logic [127:0] pt, input logic [127:0] k, input logic hold, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         plaintext = pt;
         key       = k;
         in_valid  = 1'b1;
         @(posedge clk);
         #1;
         if (!hold) in_valid = 1'b0;
      end
   endtask

   // Counts edges after the accept until out_valid is seen.
   task automatic wait_out(output int lat, output logic ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = 128'h0; key = 128'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (ciphertext !== 128'h0) begin n_bad++; $display("FAIL reset_ct got %h want 0", ciphertext); end
   endtask

   task automatic test_vector(input string nm, input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
      logic ok;
      int   lat;
      logic [127:0] held;
      accept_block(pt, k, 1'b0, ok);
      wait_out(lat, ok);
      n_cmp++; if (!ok || lat != 10) begin n_bad++; $display("FAIL %s_latency got %0d (ok=%b) want 10", nm, lat, ok); end
      n_cmp++; if (ciphertext !== ct) begin n_bad++; $display("FAIL %s_ct got %h want %h", nm, ciphertext, ct); end
      n_cmp++; if (ciphertext !== aes_ref(pt, k)) begin n_bad++; $display("FAIL %s_model got %h want %h", nm, ciphertext, aes_ref(pt, k)); end
      held = ciphertext;
      consume();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_release got ov=%b ir=%b want 0/1", nm, out_valid, in_ready); end
      n_cmp++; if (ciphertext !== held) begin n_bad++; $display("FAIL %s_ct_hold got %h want %h", nm, ciphertext, held); end
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, k, exp;
      logic ok;
      int   lat;
      pt = rand128(); k = rand128(); exp = aes_ref(pt, k);
      out_ready = 1'b0;
      accept_block(pt, k, 1'b0, ok);
      wait_out(lat, ok);
      n_cmp++; if (!ok || ciphertext !== exp) begin n_bad++; $display("FAIL bp_ct got %h want %h", ciphertext, exp); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (ciphertext !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall cyc %0d got ct=%h ir=%b ov=%b want ct=%h ir=0 ov=1", i, ciphertext, in_ready, out_valid, exp);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_pulse got ov=%b ir=%b want 0/1", out_valid, in_ready); end
      n_cmp++; if (ciphertext !== exp) begin n_bad++; $display("FAIL bp_ct_hold got %h want %h", ciphertext, exp); end
   endtask

   task automatic test_busy_ignore();
      logic [127:0] pt1, k1, pt2, k2;
      logic ok;
      int   lat, ir_bad;
      pt1 = rand128(); k1 = rand128(); pt2 = rand128(); k2 = rand128();
      out_ready = 1'b0;
      ir_bad = 0;
      accept_block(pt1, k1, 1'b1, ok);
      lat = 0; ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         plaintext = rand128();
         key       = rand128();
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (in_ready !== 1'b0) ir_bad++;
      end
      n_cmp++; if (!ok || lat != 10) begin n_bad++; $display("FAIL busy_latency got %0d (ok=%b) want 10", lat, ok); end
      n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL busy_in_ready got %0d cycles high want 0", ir_bad); end
      n_cmp++; if (ciphertext !== aes_ref(pt1, k1)) begin n_bad++; $display("FAIL busy_ct got %h want %h", ciphertext, aes_ref(pt1, k1)); end
      plaintext = pt2; key = k2; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_exit got ov=%b ir=%b want 0/1", out_valid, in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat, ok);
      n_cmp++; if (!ok || lat != 10) begin n_bad++; $display("FAIL busy_second_latency got %0d (ok=%b) want 10", lat, ok); end
      n_cmp++; if (ciphertext !== aes_ref(pt2, k2)) begin n_bad++; $display("FAIL busy_second_ct got %h want %h", ciphertext, aes_ref(pt2, k2)); end
      consume();
   endtask

   task automatic test_reset_mid();
      logic ok;
      accept_block(rand128(), rand128(), 1'b0, ok);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
      n_cmp++; if (ciphertext !== 128'h0) begin n_bad++; $display("FAIL rstmid_ct got %h want 0", ciphertext); end
      test_vector("rstmid_b", B_PT, B_KEY, B_CT);
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [3];
      logic [127:0] ks [3];
      logic [127:0] exp_q [$];
      int cyc, sent, got, last_acc;
      for (int i = 0; i < 3; i++) begin
         pts[i] = rand128(); ks[i] = rand128();
      end
      out_ready = 1'b1;
      cyc = 0; sent = 0; got = 0; last_acc = -1;
      while (got < 3 && cyc < 200) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_unexpected got ct=%h want no output", ciphertext);
            end else if (ciphertext !== exp_q[0]) begin
               n_bad++; $display("FAIL b2b_ct%0d got %h want %h", got, ciphertext, exp_q[0]);
            end else begin
               n_bad = n_bad + 0;
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (sent < 3) begin
            in_valid = 1'b1; plaintext = pts[sent]; key = ks[sent];
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready === 1'b1) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (cyc - last_acc != 12) begin n_bad++; $display("FAIL b2b_spacing got %0d want 12", cyc - last_acc); end
            end
            last_acc = cyc;
            exp_q.push_back(aes_ref(pts[sent], ks[sent]));
            sent++;
         end
         @(posedge clk);
         cyc++;
      end
      n_cmp++; if (got != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", got); end
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_vector("fips_b", B_PT, B_KEY, B_CT);
      test_vector("fips_c", C_PT, C_KEY, C_CT);
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES-128 encryption engine that turns one 128-bit plaintext block and a 128-bit cipher key into a ciphertext block. It runs one round per clock, computes the key schedule on the fly, and uses a valid/ready handshake on both input and output. It is the forward-direction counterpart of the decryption datapath and sits in front of the link framing logic. Its round datapath reuses the team's forward primitives: SubBytes, ShiftRows and MixColumns.

## Interface
- No parameters. Key length is fixed at 128 bits and Nr is fixed at 10.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key pair is presented.
- in_ready  out  1  core is idle and can accept a block.
- plaintext  in  128  input block. Bits [127:120] are byte 0. Bytes are column-major: byte n is row n%4, column n/4.
- key  in  128  cipher key, same byte order as plaintext.
- out_valid  out  1  ciphertext is valid and held stable.
- out_ready  in  1  downstream accepts the ciphertext.
- ciphertext  out  128  result block, same byte order.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: rounds 1..10.
  - DONE: out_valid=1.
- IDLE, on in_valid&&in_ready:
  - state_reg <= plaintext ^ key (round 0 AddRoundKey).
  - rk_reg <= key.
  - rcon <= 8'h01.
  - rnd <= 1.
  - Go to RUN.
- RUN, each cycle:
  - next_rk = KeyExpansion(rk_reg, rcon).
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
    - wi' = wi ^ w(i-1)' for i=1..3.
  - For rnd 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
  - For rnd 10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ next_rk. MixColumns is skipped.
  - rk_reg <= next_rk.
  - rcon <= xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 0).
  - Sequence of rcon values: 01,02,04,08,10,20,40,80,1b,36.
  - rnd increments 4-bit. After rnd 10 completes, go to DONE.
- DONE:
  - ciphertext = state_reg; out_valid=1.
  - On out_ready: go to IDLE. ciphertext keeps its last value; only out_valid drops.
- plaintext and key are sampled only at the accept edge. Changes to them while in RUN or DONE are ignored.
- in_valid in RUN or DONE is not accepted, because in_ready=0. The upstream must hold its request.
- The S-box is a combinational table. Twenty S-box lookups run in parallel: 16 for state bytes and 4 for key bytes.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, ciphertext=128'h0.
  - state_reg, rk_reg and rnd are all cleared to 0.
- rst has priority over every other input. If asserted mid-RUN or in DONE, the block in flight is discarded. Next cycle is IDLE with the outputs above.
- Latency: if the accept happens at edge T, out_valid rises after edge T+10. No intermediate value is ever visible with out_valid=1.
- out_valid stays high, and ciphertext stays stable, until the edge where out_ready=1.
- in_ready rises the cycle after DONE exits. Minimum block period is 12 cycles with out_ready tied high.
- out_ready asserted in IDLE or RUN has no effect.
- If in_valid and out_ready are both asserted in DONE in the same cycle: the output is consumed and the input is not accepted. It can be accepted in the following cycle.
- The critical path is S-box → MixColumns → XOR. There is no internal pipelining; each round completes in one cycle.

## Test plan
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ciphertext 3925841d02dc09fbdc118597196a0b32. out_valid must rise exactly 10 cycles after the accept.
- FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises. ciphertext must stay stable and in_ready=0 throughout. Then pulse out_ready for 1 cycle: out_valid→0 and in_ready→1 on the next cycle.
- Input ignored while busy: change plaintext/key and hold in_valid during RUN. The result must still equal the vector sampled at accept, and a second block is accepted only after DONE exits.
- Reset mid-operation: assert rst at round 5. Next cycle must show in_ready=1, out_valid=0, ciphertext=0. A fresh App. B vector then produces the correct result.
- Back-to-back: run 3 random vectors with out_ready=1 and check each against a software model. Accept-to-accept spacing must be 12 cycles.
